// File: rtl/rr_input_pkg.sv
// Shared types and constants for the fighter input front end.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package rr_input_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_J_WAIT   = 3'd1,
        ST_K_WAIT   = 3'd2,
        ST_CHORD    = 3'd3,
        ST_SINGLE_J = 3'd4,
        ST_SINGLE_K = 3'd5,
        ST_RELEASE  = 3'd6
    } chord_state_t;

    localparam logic [7:0] HID_J    = 8'h0D;
    localparam logic [7:0] HID_K    = 8'h0E;
    localparam logic [7:0] HID_NONE = 8'h00;

    localparam int DEF_CHORD_WIN = 4;
    localparam int DEF_STEP_DIV  = 6;

    // True when any of the four HID slots carries 'code'. An empty slot
    // (HID_NONE) never counts as a key, and duplicates collapse to one hit.
    function automatic logic key_in_slots(input logic [31:0] kc, input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (code != HID_NONE && kc[8*i +: 8] == code) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-sample frame-rate debouncer for one key.
// Latency: a new level is accepted on the second consecutive tick it is seen.
// Backpressure: none; state advances only on tick.
module key_debounce (
    input  logic Clk,
    input  logic Reset_n,
    input  logic tick,
    input  logic raw,
    output logic deb
);

    logic prev_q;
    logic deb_q;

    // Accept raw only when it matches the previous tick's sample.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            prev_q <= 1'b0;
            deb_q  <= 1'b0;
        end else if (tick) begin
            prev_q <= raw;
            if (raw == prev_q) begin
                deb_q <= raw;
            end
        end
    end

    assign deb = deb_q;

endmodule

// File: rtl/key_chord_input.sv
// J/K key detect, debounce and chord classification plus animation step divider.
// Latency: chord visible 3 ticks after both keys appear; single press after 3+CHORD_WIN ticks.
// Backpressure: none; all state advances only on frame_tick.
module key_chord_input
    import rr_input_pkg::*;
#(
    parameter logic [7:0] KEY_J     = HID_J,
    parameter logic [7:0] KEY_K     = HID_K,
    parameter int         CHORD_WIN = DEF_CHORD_WIN,
    parameter int         STEP_DIV  = DEF_STEP_DIV
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [31:0] keycode,
    input  logic        frame_tick,
    output logic        J_Press,
    output logic        K_Press,
    output logic        anim_step
);

    localparam logic [3:0] WIN_LAST = 4'(CHORD_WIN - 1);
    localparam logic [5:0] DIV_LAST = 6'(STEP_DIV - 1);

    logic         j_raw;
    logic         k_raw;
    logic         deb_j;
    logic         deb_k;
    chord_state_t state_q;
    chord_state_t state_d;
    logic [3:0]   win_cnt_q;
    logic [3:0]   win_cnt_d;
    logic [5:0]   div_cnt_q;
    logic [5:0]   div_cnt_d;
    logic         anim_step_q;
    logic         anim_step_d;

    assign j_raw = key_in_slots(keycode, KEY_J);
    assign k_raw = key_in_slots(keycode, KEY_K);

    key_debounce u_deb_j (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .tick    (frame_tick),
        .raw     (j_raw),
        .deb     (deb_j)
    );

    key_debounce u_deb_k (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .tick    (frame_tick),
        .raw     (k_raw),
        .deb     (deb_k)
    );

    // Chord classifier: a lone key waits CHORD_WIN ticks for its partner
    // before committing to a single press; a chord only exits via RELEASE.
    always_comb begin
        state_d   = state_q;
        win_cnt_d = win_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (deb_j && deb_k) begin
                    state_d = ST_CHORD;
                end else if (deb_j) begin
                    state_d   = ST_J_WAIT;
                    win_cnt_d = 4'd0;
                end else if (deb_k) begin
                    state_d   = ST_K_WAIT;
                    win_cnt_d = 4'd0;
                end
            end
            ST_J_WAIT: begin
                if (deb_k) begin
                    state_d = ST_CHORD;
                end else if (!deb_j) begin
                    state_d = ST_IDLE;
                end else if (win_cnt_q == WIN_LAST) begin
                    state_d = ST_SINGLE_J;
                end else begin
                    win_cnt_d = win_cnt_q + 4'd1;
                end
            end
            ST_K_WAIT: begin
                if (deb_j) begin
                    state_d = ST_CHORD;
                end else if (!deb_k) begin
                    state_d = ST_IDLE;
                end else if (win_cnt_q == WIN_LAST) begin
                    state_d = ST_SINGLE_K;
                end else begin
                    win_cnt_d = win_cnt_q + 4'd1;
                end
            end
            ST_CHORD: begin
                if (!deb_j || !deb_k) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_SINGLE_J: begin
                if (!deb_j) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_SINGLE_K: begin
                if (!deb_k) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!deb_j && !deb_k) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Frame divider; the strobe is computed every cycle so it lasts one cycle.
    always_comb begin
        div_cnt_d   = (div_cnt_q == DIV_LAST) ? 6'd0 : div_cnt_q + 6'd1;
        anim_step_d = frame_tick && (div_cnt_q == DIV_LAST);
    end

    // State register: FSM and counters move on ticks, strobe every cycle.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            win_cnt_q   <= 4'd0;
            div_cnt_q   <= 6'd0;
            anim_step_q <= 1'b0;
        end else begin
            anim_step_q <= anim_step_d;
            if (frame_tick) begin
                state_q   <= state_d;
                win_cnt_q <= win_cnt_d;
                div_cnt_q <= div_cnt_d;
            end
        end
    end

    assign J_Press   = (state_q == ST_SINGLE_J) || (state_q == ST_CHORD);
    assign K_Press   = (state_q == ST_SINGLE_K) || (state_q == ST_CHORD);
    assign anim_step = anim_step_q;

endmodule

// File: tb/tb_key_chord_input.sv
// Directed scenarios followed by random frames, every cycle compared to a frame-level model.
module tb_key_chord_input;

    localparam int CW = 4;
    localparam int SD = 6;

    // Model classification modes (independent of the RTL encoding).
    localparam int M_IDLE = 10, M_WAIT_J = 11, M_WAIT_K = 12, M_BOTH = 13;
    localparam int M_ONLY_J = 14, M_ONLY_K = 15, M_DRAIN = 16;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [31:0] keycode;
    logic        frame_tick;
    logic        J_Press;
    logic        K_Press;
    logic        anim_step;

    always #5 Clk = ~Clk;

    key_chord_input #(
        .KEY_J     (8'h0D),
        .KEY_K     (8'h0E),
        .CHORD_WIN (CW),
        .STEP_DIV  (SD)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .keycode    (keycode),
        .frame_tick (frame_tick),
        .J_Press    (J_Press),
        .K_Press    (K_Press),
        .anim_step  (anim_step)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    bit m_seen_j, m_seen_k;   // last tick's raw sample
    bit m_acc_j, m_acc_k;     // accepted (stable) key levels
    int m_mode;
    int m_waited;             // ticks spent waiting for a partner key
    int m_frames;             // ticks since reset
    bit m_step;

    function automatic bit has_code(input logic [31:0] kc, input logic [7:0] code);
        for (int i = 0; i < 4; i++) begin
            if (((kc >> (8 * i)) & 32'hFF) == 32'(code)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_seen_j = 0; m_seen_k = 0; m_acc_j = 0; m_acc_k = 0;
        m_mode = M_IDLE; m_waited = 0; m_frames = 0; m_step = 0;
    endtask

    task automatic model_frame(input logic [31:0] kc);
        bit rj, rk, aj, ak;
        rj = has_code(kc, 8'h0D);
        rk = has_code(kc, 8'h0E);
        aj = m_acc_j;
        ak = m_acc_k;
        if (rj == m_seen_j) m_acc_j = rj;
        if (rk == m_seen_k) m_acc_k = rk;
        m_seen_j = rj;
        m_seen_k = rk;
        if (m_mode == M_IDLE) begin
            if (aj && ak) m_mode = M_BOTH;
            else if (aj) begin m_mode = M_WAIT_J; m_waited = 0; end
            else if (ak) begin m_mode = M_WAIT_K; m_waited = 0; end
        end else if (m_mode == M_WAIT_J || m_mode == M_WAIT_K) begin
            bit mine, other;
            mine  = (m_mode == M_WAIT_J) ? aj : ak;
            other = (m_mode == M_WAIT_J) ? ak : aj;
            if (other) m_mode = M_BOTH;
            else if (!mine) m_mode = M_IDLE;
            else begin
                m_waited++;
                if (m_waited == CW) m_mode = (m_mode == M_WAIT_J) ? M_ONLY_J : M_ONLY_K;
            end
        end else if (m_mode == M_BOTH) begin
            if (!(aj && ak)) m_mode = M_DRAIN;
        end else if (m_mode == M_ONLY_J) begin
            if (!aj) m_mode = M_DRAIN;
        end else if (m_mode == M_ONLY_K) begin
            if (!ak) m_mode = M_DRAIN;
        end else if (m_mode == M_DRAIN) begin
            if (!aj && !ak) m_mode = M_IDLE;
        end
    endtask

    // ---------------- observation helpers ----------------
    int tick_no;
    int j_rise_at, j_fall_at, k_rise_at;
    bit seen_jp, seen_kp, prev_jp, prev_kp;
    int step_at[$];

    task automatic mark();
        tick_no = 0; j_rise_at = -1; j_fall_at = -1; k_rise_at = -1;
        seen_jp = 0; seen_kp = 0;
        step_at.delete();
    endtask

    // Compare current outputs, then drive the next cycle's inputs.
    task automatic cycle(input logic r, input logic [31:0] k, input logic t);
        chk("J_Press", J_Press, (m_mode == M_ONLY_J || m_mode == M_BOTH));
        chk("K_Press", K_Press, (m_mode == M_ONLY_K || m_mode == M_BOTH));
        chk("anim_step", anim_step, m_step);
        if (J_Press && !prev_jp) j_rise_at = tick_no;
        if (!J_Press && prev_jp) j_fall_at = tick_no;
        if (K_Press && !prev_kp) k_rise_at = tick_no;
        prev_jp = J_Press;
        prev_kp = K_Press;
        seen_jp |= J_Press;
        seen_kp |= K_Press;
        if (anim_step) step_at.push_back(tick_no);
        Reset_n = r; keycode = k; frame_tick = t;
        if (!r) begin
            model_reset();
        end else begin
            m_step = t && ((m_frames % SD) == SD - 1);
            if (t) begin
                m_frames++;
                model_frame(k);
                tick_no++;
            end
        end
        @(negedge Clk);
    endtask

    task automatic ticks(input logic [31:0] k, input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, k, 1'b1);
            cycle(1'b1, k, 1'b0);
        end
    endtask

    function automatic logic [7:0] noise_byte();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == 8'h0D || b == 8'h0E) b = 8'h20;
        if ($urandom_range(0, 1) == 0) b = 8'h00;
        return b;
    endfunction

    initial begin
        logic [31:0] kc;
        bit hold_j, hold_k;
        int sj, sk;
        Reset_n = 1'b0; keycode = 32'h0; frame_tick = 1'b0;
        prev_jp = 0; prev_kp = 0;
        model_reset();
        mark();
        @(negedge Clk);

        // Reset while J is held, then J must wait for a fresh debounce.
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0000_000D, 1'b1);
        mark();
        ticks(32'h0000_000D, 10);
        chk("rst_j_rise_tick", j_rise_at, 7);
        chk("rst_k_never", seen_kp, 0);
        ticks(32'h0000_0D00, 3);
        chk("slot1_hold_j", J_Press, 1);
        mark();
        ticks(32'h0, 6);
        chk("j_release_tick", j_fall_at, 3);

        // J first, K joins on tick 3: chord via the wait window.
        mark();
        ticks(32'h0000_000D, 2);
        ticks(32'h0E00_000D, 5);
        chk("chord_j_tick", j_rise_at, 5);
        chk("chord_k_tick", k_rise_at, 5);
        mark();
        ticks(32'h0000_000D, 6);
        chk("partial_release_tick", j_fall_at, 3);
        chk("partial_release_j", J_Press, 0);
        ticks(32'h0, 5);

        // Short J tap and a one-tick K glitch produce nothing.
        mark();
        ticks(32'h000D_0000, 3);
        ticks(32'h0, 6);
        chk("tap_no_press", seen_jp, 0);
        mark();
        ticks(32'h0E00_0000, 1);
        ticks(32'h0, 5);
        chk("glitch_no_press", seen_kp, 0);

        // Step divider across 18 ticks with three back-to-back tick cycles.
        cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        mark();
        for (int i = 1; i <= 18; i++) begin
            cycle(1'b1, 32'h0, 1'b1);
            if (i < 10 || i >= 12) cycle(1'b1, 32'h0, 1'b0);
        end
        cycle(1'b1, 32'h0, 1'b0);
        chk("step_count", step_at.size(), 3);
        if (step_at.size() == 3) begin
            chk("step_tick_a", step_at[0], 6);
            chk("step_tick_b", step_at[1], 12);
            chk("step_tick_c", step_at[2], 18);
        end

        // Random frames: sticky key holds, slot shuffling, noise, resets.
        hold_j = 0; hold_k = 0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 15) == 0) hold_j = !hold_j;
            if ($urandom_range(0, 15) == 0) hold_k = !hold_k;
            for (int s = 0; s < 4; s++) kc[8*s +: 8] = noise_byte();
            sj = $urandom_range(0, 3);
            sk = (sj + $urandom_range(1, 3)) % 4;
            if (hold_j) begin
                kc[8*sj +: 8] = 8'h0D;
                if ($urandom_range(0, 3) == 0) kc[8*((sj + 2) % 4) +: 8] = 8'h0D;
            end
            if (hold_k) kc[8*sk +: 8] = 8'h0E;
            cycle(($urandom_range(0, 299) != 0), kc, $urandom_range(0, 1) == 1);
        end
        cycle(1'b1, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/key_chord_input.md
# key_chord_input

Front-end input stage for the fighter animation controller. Each frame it takes the four USB HID keycode slots, finds the J and K keys, debounces them and classifies them as a J-only press, a K-only press or a J+K chord inside a short window. It drives registered `J_Press`/`K_Press` levels that the animation FSM uses directly. It also produces an `anim_step` strobe every `STEP_DIV` frames to pace animation steps.

## Interface
- `KEY_J`, default 8'h0D: HID usage code for J.
- `KEY_K`, default 8'h0E: HID usage code for K.
- `CHORD_WIN`, default 4: frames allowed for the second key to join a chord; legal range 1..15.
- `STEP_DIV`, default 6: frame ticks per `anim_step` pulse; legal range 1..63.
- `Clk` input 1: system clock; the only clock.
- `Reset_n` input 1: reset, synchronous and active-low.
- `keycode` input 32: four HID keycode slots, bits [7:0], [15:8], [23:16], [31:24].
- `frame_tick` input 1: one-cycle pulse per video frame (vsync).
- `J_Press` output 1: J-only press, or chord, is active.
- `K_Press` output 1: K-only press, or chord, is active.
- `anim_step` output 1: one-cycle animation step strobe.

## Operation
- Raw detect (combinational):
  - `j_raw` = any slot == `KEY_J`; `k_raw` = any slot == `KEY_K`.
  - Slots equal to 8'h00 never match.
  - Duplicate slots count as one press.
- All sequential state updates only in cycles with `frame_tick`=1.
- Debounce, per key:
  - Registers `prev` and `deb`.
  - On each tick: `deb <= raw` if `raw == prev`; `prev <= raw` always.
  - A level must be present on two consecutive ticks before it is accepted.
- Chord FSM states: IDLE, J_WAIT, K_WAIT, CHORD, SINGLE_J, SINGLE_K, RELEASE. Window counter `win_cnt` is 4 bits.
- Transitions on a tick, evaluated on the current `deb_j`/`deb_k`; higher rows have priority:
  - IDLE:
    - both keys → CHORD
    - J only → J_WAIT, `win_cnt`=0
    - K only → K_WAIT, `win_cnt`=0
  - J_WAIT:
    - `deb_k` → CHORD
    - `!deb_j` → IDLE; a short tap produces no output
    - `win_cnt == CHORD_WIN-1` → SINGLE_J
    - otherwise `win_cnt++`
  - K_WAIT: mirror of J_WAIT, with the roles of J and K swapped.
  - CHORD: either key released → RELEASE.
  - SINGLE_J: `!deb_j` → RELEASE. A K press while in this state is ignored.
  - SINGLE_K: `!deb_k` → RELEASE.
  - RELEASE: both keys released → IDLE.
- Outputs are decoded from the state register only:
  - `J_Press` = SINGLE_J | CHORD.
  - `K_Press` = SINGLE_K | CHORD.
  - A partial release from CHORD drops both outputs; a chord never degrades to a single press.
- Step divider:
  - `div_cnt` counts 0..`STEP_DIV`-1 on ticks and wraps to 0.
  - `anim_step` <= `frame_tick & (div_cnt == STEP_DIV-1)`, registered.

## Timing
- Reset (`Reset_n`=0 at a rising edge) forces:
  - state IDLE;
  - `prev`, `deb`, `win_cnt`, `div_cnt` = 0;
  - `J_Press`, `K_Press`, `anim_step` = 0.
- Reset applied mid-chord clears everything the same way. After reset, a key still held needs two fresh ticks to be re-accepted.
- Ticks are numbered from the first tick with the key present:
  - `deb` rises at tick 2; the FSM reacts at tick 3.
  - Chord latency: both keys present before tick 1 → CHORD after tick 3; outputs high from the next cycle.
  - Single press latency: J_WAIT entered at tick 3, SINGLE_J at tick 3+`CHORD_WIN`. For `CHORD_WIN`=4, `J_Press` rises the cycle after tick 7.
- Release: keys removed before tick n → `deb` falls at tick n+1 → RELEASE at tick n+2 → IDLE at tick n+3.
- `frame_tick` high in consecutive cycles counts as consecutive ticks.
- `keycode` changing between ticks has no effect.
- `anim_step` is a single-cycle pulse. With `STEP_DIV`=1 it fires on every tick.

## Structure
- Package `rr_input_pkg`:
  - `chord_state_t` enum (3 bits);
  - HID constants `HID_J`, `HID_K`, `HID_NONE`;
  - default `CHORD_WIN` and `STEP_DIV` values.
- Sub-module `key_debounce`: inputs `Clk`, `Reset_n`, `tick`, `raw`; output `deb`. Instantiated twice, once per key.
- The FSM, the window counter and the step divider live in the top module.

## Test plan
- Reset: keycode=0x0D held, `Reset_n` low for 3 cycles → all outputs 0. After release, `J_Press` stays 0 until tick 7.
- J alone in slot [15:8] held 10 ticks, `CHORD_WIN`=4 → `J_Press` high from the cycle after tick 7; `K_Press` stays 0; both low 3 ticks after the key is removed.
- J at tick 1, K added at tick 3 → CHORD entered at tick 5 via J_WAIT; `J_Press`=`K_Press`=1. Releasing K only → both 0, RELEASE held until J is also released.
- J tap present on ticks 1–3 only → J_WAIT is entered then returns to IDLE; `J_Press` never asserts.
- One-tick glitch of 0x0E, present at tick 1 only → `deb_k` never rises; FSM stays in IDLE.
- `STEP_DIV`=6 with 18 ticks, including 3 back-to-back tick cycles → exactly 3 `anim_step` pulses, each 1 cycle wide, one cycle after ticks 6, 12 and 18.
